// File: rtl/imm_encoder_if.sv
// Handshake and data bundle for imm_encoder: an immediate/type/base-word input
// stream and an encoded-instruction output stream.
interface imm_encoder_if #(
  parameter int XLEN      = 32,
  parameter int ERR_CNT_W = 8
);
  logic                 inValid;
  logic                 inReady;
  logic [XLEN-1:0]      immValue;
  logic [2:0]           immSrc;
  logic [XLEN-1:0]      baseInstr;
  logic                 outValid;
  logic                 outReady;
  logic [XLEN-1:0]      instr;
  logic                 rangeErr;
  logic [ERR_CNT_W-1:0] errCount;

  modport master (
    output inValid, immValue, immSrc, baseInstr, outReady,
    input  inReady, outValid, instr, rangeErr, errCount
  );

  modport slave (
    input  inValid, immValue, immSrc, baseInstr, outReady,
    output inReady, outValid, instr, rangeErr, errCount
  );
endinterface

// File: rtl/imm_encoder.sv
// RV32I immediate encoder: scatters an immediate into the I/S/B/U/J fields of a
// base instruction, flags values that do not fit, two-stage valid/ready pipe.
module imm_encoder #(
  parameter int XLEN      = 32,
  parameter int ERR_CNT_W = 8
) (
  input logic          clk,
  input logic          rstN,
  imm_encoder_if.slave bus
);

  localparam logic [2:0] SRC_I = 3'd0;
  localparam logic [2:0] SRC_S = 3'd1;
  localparam logic [2:0] SRC_B = 3'd2;
  localparam logic [2:0] SRC_U = 3'd3;
  localparam logic [2:0] SRC_J = 3'd4;

  logic [XLEN-1:0]      enc_instr;
  logic                 enc_err;
  logic                 fits_12;
  logic                 fits_13;
  logic                 fits_21;

  logic                 s1_valid_q, s1_valid_d;
  logic [XLEN-1:0]      s1_instr_q, s1_instr_d;
  logic                 s1_err_q,   s1_err_d;
  logic                 s2_valid_q, s2_valid_d;
  logic [XLEN-1:0]      s2_instr_q, s2_instr_d;
  logic                 s2_err_q,   s2_err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q,  err_cnt_d;

  logic                 s2_free;
  logic                 s1_adv;
  logic                 in_ready;
  logic                 accept;
  logic                 deliver;

  // A signed value fits in N bits when everything from bit N-1 up is a copy of the sign.
  always_comb begin
    fits_12 = (bus.immValue[31:11] == '0) || (bus.immValue[31:11] == '1);
    fits_13 = (bus.immValue[31:12] == '0) || (bus.immValue[31:12] == '1);
    fits_21 = (bus.immValue[31:20] == '0) || (bus.immValue[31:20] == '1);
  end

  always_comb begin
    enc_instr = bus.baseInstr;
    enc_err   = 1'b1;
    unique case (bus.immSrc)
      SRC_I: begin
        enc_instr = {bus.immValue[11:0], bus.baseInstr[19:0]};
        enc_err   = !fits_12;
      end
      SRC_S: begin
        enc_instr = {bus.immValue[11:5], bus.baseInstr[24:12],
                     bus.immValue[4:0], bus.baseInstr[6:0]};
        enc_err   = !fits_12;
      end
      SRC_B: begin
        enc_instr = {bus.immValue[12], bus.immValue[10:5], bus.baseInstr[24:12],
                     bus.immValue[4:1], bus.immValue[11], bus.baseInstr[6:0]};
        enc_err   = !fits_13 || bus.immValue[0];
      end
      SRC_U: begin
        enc_instr = {bus.immValue[31:12], bus.baseInstr[11:0]};
        enc_err   = (bus.immValue[11:0] != '0);
      end
      SRC_J: begin
        enc_instr = {bus.immValue[20], bus.immValue[10:1], bus.immValue[11],
                     bus.immValue[19:12], bus.baseInstr[11:0]};
        enc_err   = !fits_21 || bus.immValue[0];
      end
      default: begin
        enc_instr = bus.baseInstr;
        enc_err   = 1'b1;
      end
    endcase
  end

  // S2 frees up when empty or being drained; S1 may then move down and refill.
  always_comb begin
    s2_free  = !s2_valid_q || bus.outReady;
    s1_adv   = s1_valid_q && s2_free;
    in_ready = rstN && (!s1_valid_q || s2_free);
    accept   = bus.inValid && in_ready;
    deliver  = s2_valid_q && bus.outReady;

    s1_valid_d = accept || (s1_valid_q && !s1_adv);
    s1_instr_d = s1_instr_q;
    s1_err_d   = s1_err_q;
    if (accept) begin
      s1_instr_d = enc_instr;
      s1_err_d   = enc_err;
    end

    s2_valid_d = s1_adv || (s2_valid_q && !bus.outReady);
    s2_instr_d = s2_instr_q;
    s2_err_d   = s2_err_q;
    if (s1_adv) begin
      s2_instr_d = s1_instr_q;
      s2_err_d   = s1_err_q;
    end

    err_cnt_d = err_cnt_q;
    if (deliver && s2_err_q && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      s1_valid_q <= 1'b0;
      s1_instr_q <= '0;
      s1_err_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_instr_q <= '0;
      s2_err_q   <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_instr_q <= s1_instr_d;
      s1_err_q   <= s1_err_d;
      s2_valid_q <= s2_valid_d;
      s2_instr_q <= s2_instr_d;
      s2_err_q   <= s2_err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign bus.inReady  = in_ready;
  assign bus.outValid = s2_valid_q;
  assign bus.instr    = s2_instr_q;
  assign bus.rangeErr = s2_err_q;
  assign bus.errCount = err_cnt_q;

endmodule
